result_bus_arbiter: RTL and testbench
=====================================

# result_bus_arbiter

Round-robin arbiter sharing the common data bus (CDB) and the ROB write port among NFU functional units, such as the shift, ALU and memory FUs. Each FU's output stage holds its result and raises a request. The arbiter grants at most one FU per channel per cycle with a one-hot acknowledge, then drives the winner's payload onto the registered CDB or ROB broadcast the following cycle. The two channels arbitrate independently, each with its own rotating priority pointer.

## Interface
- NFU, 4, number of FU requesters (2..8)
- ID_W, 4, ROB id width
- DATA_W, 8, value/flags/wbs width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  pipeline flush; clears broadcasts and blocks grants this cycle
- fu_cdb_req  in  NFU  per-FU CDB request (FU cdb_transmit_out)
- fu_cdb_id  in  NFU×ID_W  per-FU CDB tag
- fu_cdb_val  in  NFU×DATA_W  per-FU CDB value
- fu_cdb_ack  out  NFU  one-hot CDB grant, fed to FU cdb_transmit
- cdb_valid  out  1  registered CDB broadcast valid
- cdb_id  out  ID_W  registered CDB tag
- cdb_val  out  DATA_W  registered CDB value
- fu_rob_req  in  NFU  per-FU ROB request (FU rob_transmit_out)
- fu_rob_robid  in  NFU×ID_W  per-FU ROB id
- fu_rob_flags  in  NFU×DATA_W  per-FU flags
- fu_rob_wbs  in  NFU×DATA_W  per-FU writeback select
- fu_rob_value  in  NFU×DATA_W  per-FU result
- rob_ready  in  1  ROB can accept a write this cycle
- fu_rob_ack  out  NFU  one-hot ROB grant, fed to FU rob_transmit
- rob_valid  out  1  registered ROB write valid
- rob_robid, rob_flags, rob_wbs, rob_value  out  ID_W/DATA_W  registered ROB write payload

## Operation
- Each channel holds a pointer ptr (log2 NFU bits) that marks the highest-priority FU.
- Winner = first asserted req scanning ptr, ptr+1, … mod NFU.
- fu_*_ack is combinational from the current req, ptr and the gate inputs. It is one-hot or zero.
- Gating:
  - CDB grant requires !flush && !rst.
  - ROB grant additionally requires rob_ready.
- On a grant to FU k:
  - The channel registers the winner's payload and sets its valid on the next edge.
  - ptr becomes (k+1) mod NFU.
- With no grant: valid clears next edge, payload registers hold their value, ptr is unchanged.
- The FU deasserts req after seeing ack. A req still high one cycle after its ack is a new result and is arbitrated normally.
- Channels are fully independent. One FU may win CDB and ROB in the same cycle.
- Ack outputs are never generated for FUs whose req is low.

## Timing
- Reset (sync) sets:
  - cdb_valid=0 and rob_valid=0;
  - all payload outputs = 0;
  - both ptr = 0;
  - acks = 0 while rst is high.
- Latency: req sampled in cycle N → ack in cycle N → broadcast valid in cycle N+1 for exactly one cycle per grant.
- Throughput: one grant per channel per cycle. Back-to-back grants to different FUs give continuous valid.
- Fairness: a continuously requesting FU waits at most NFU−1 grants on its channel.
- flush in cycle N:
  - no acks in N;
  - valids are 0 at N+1;
  - a broadcast already valid in N still completes in N.
  - Pointers hold.
- rob_ready low: ROB acks are 0 and ROB requests wait; CDB arbitration is unaffected.
- Pointer wrap: a grant to FU NFU−1 sets ptr to 0.
- rst mid-operation: pending requests are dropped from the arbiter's view. Nothing is acknowledged during reset.

## Test plan
- Reset: hold rst 2 cycles with all reqs high → acks 0, valids 0, payloads 0. After release, the first CDB grant goes to FU0.
- Round-robin: all 4 fu_cdb_req held high, ids 1..4 → acks to FU0,1,2,3,0 on successive cycles; cdb_id 1,2,3,4,1 one cycle later; cdb_valid continuously 1.
- Single FU: only FU2 requests, with id=7 and val=0x80 → ack[2] in the same cycle; next cycle cdb_valid=1, cdb_id=7, cdb_val=0x80; ptr=3.
- ROB backpressure: FU1 rob req with robid=5, rob_ready=0 for 3 cycles → no ack, rob_valid=0. When rob_ready=1 → ack[1]; next cycle rob_valid=1, rob_robid=5. CDB grants proceed during the stall.
- Flush: reqs from FU0 and FU3 with flush pulsed → no acks that cycle, valids 0 next cycle. Next cycle with flush low → FU0 granted (ptr unchanged).
- Dual channel: FU3 requests both CDB and ROB → both acks to FU3 in the same cycle; cdb_valid and rob_valid both 1 next cycle; both ptr=0.

Source files
------------

// File: rtl/result_bus_arbiter.sv
// -----------------------------------------------------------------------------
// result_bus_arbiter
//
// Shares the common data bus (CDB) and the ROB write port among NFU functional
// units. Each channel runs its own round-robin arbiter. The grant (one-hot ack)
// is combinational in the request cycle. The winner's payload is broadcast from
// registers on the following cycle.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             blocks all grants this cycle, so both valids drop next cycle
//   fu_cdb_req/id/val per-FU CDB request and payload (flattened, FU k at slice k)
//   fu_cdb_ack        one-hot CDB grant back to the FUs
//   cdb_valid/id/val  registered CDB broadcast
//   fu_rob_req/robid/flags/wbs/value  per-FU ROB request and payload
//   rob_ready         ROB can accept a write this cycle
//   fu_rob_ack        one-hot ROB grant back to the FUs
//   rob_valid/robid/flags/wbs/value   registered ROB write
// -----------------------------------------------------------------------------
module result_bus_arbiter #(
  parameter int NFU    = 4,
  parameter int ID_W   = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,

  input  logic [NFU-1:0]         fu_cdb_req,
  input  logic [NFU*ID_W-1:0]    fu_cdb_id,
  input  logic [NFU*DATA_W-1:0]  fu_cdb_val,
  output logic [NFU-1:0]         fu_cdb_ack,
  output logic                   cdb_valid,
  output logic [ID_W-1:0]        cdb_id,
  output logic [DATA_W-1:0]      cdb_val,

  input  logic [NFU-1:0]         fu_rob_req,
  input  logic [NFU*ID_W-1:0]    fu_rob_robid,
  input  logic [NFU*DATA_W-1:0]  fu_rob_flags,
  input  logic [NFU*DATA_W-1:0]  fu_rob_wbs,
  input  logic [NFU*DATA_W-1:0]  fu_rob_value,
  input  logic                   rob_ready,
  output logic [NFU-1:0]         fu_rob_ack,
  output logic                   rob_valid,
  output logic [ID_W-1:0]        rob_robid,
  output logic [DATA_W-1:0]      rob_flags,
  output logic [DATA_W-1:0]      rob_wbs,
  output logic [DATA_W-1:0]      rob_value
);

  localparam int PTR_W = $clog2(NFU);

  logic [PTR_W-1:0]  cdb_ptr, cdb_ptr_nxt;
  logic [PTR_W-1:0]  rob_ptr, rob_ptr_nxt;
  logic              cdb_en, rob_en;

  logic [ID_W-1:0]   cdb_id_mux;
  logic [DATA_W-1:0] cdb_val_mux;
  logic [ID_W-1:0]   rob_robid_mux;
  logic [DATA_W-1:0] rob_flags_mux, rob_wbs_mux, rob_value_mux;

  // Scan ptr, ptr+1, ... (mod NFU) and grant the first requester found.
  // The modulo keeps the scan correct for non-power-of-two NFU.
  function automatic logic [NFU-1:0] rr_pick(input logic [NFU-1:0] req,
                                             input logic [PTR_W-1:0] ptr);
    logic [NFU-1:0] gnt;
    logic           found;
    int             idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NFU; i++) begin
      idx = (int'(ptr) + i) % NFU;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Reset is included in the gate so nothing is acknowledged while rst is
  // high; a requesting FU keeps its result and retries after reset.
  assign cdb_en = !flush && !rst;
  assign rob_en = cdb_en && rob_ready;

  assign fu_cdb_ack = cdb_en ? rr_pick(fu_cdb_req, cdb_ptr) : '0;
  assign fu_rob_ack = rob_en ? rr_pick(fu_rob_req, rob_ptr) : '0;

  // Payload select and next pointer, driven by the one-hot ack.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    cdb_id_mux    = '0;
    cdb_val_mux   = '0;
    cdb_ptr_nxt   = cdb_ptr;
    rob_robid_mux = '0;
    rob_flags_mux = '0;
    rob_wbs_mux   = '0;
    rob_value_mux = '0;
    rob_ptr_nxt   = rob_ptr;
    for (int k = 0; k < NFU; k++) begin
      if (fu_cdb_ack[k]) begin
        cdb_id_mux  = fu_cdb_id[k*ID_W +: ID_W];
        cdb_val_mux = fu_cdb_val[k*DATA_W +: DATA_W];
        cdb_ptr_nxt = PTR_W'((k + 1) % NFU);
      end
      if (fu_rob_ack[k]) begin
        rob_robid_mux = fu_rob_robid[k*ID_W +: ID_W];
        rob_flags_mux = fu_rob_flags[k*DATA_W +: DATA_W];
        rob_wbs_mux   = fu_rob_wbs[k*DATA_W +: DATA_W];
        rob_value_mux = fu_rob_value[k*DATA_W +: DATA_W];
        rob_ptr_nxt   = PTR_W'((k + 1) % NFU);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_id    <= '0;
      cdb_val   <= '0;
      cdb_ptr   <= '0;
    end else begin
      // Valid pulses for exactly one cycle per grant; payload holds otherwise.
      cdb_valid <= |fu_cdb_ack;
      if (|fu_cdb_ack) begin
        cdb_id  <= cdb_id_mux;
        cdb_val <= cdb_val_mux;
        cdb_ptr <= cdb_ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rob_valid <= 1'b0;
      rob_robid <= '0;
      rob_flags <= '0;
      rob_wbs   <= '0;
      rob_value <= '0;
      rob_ptr   <= '0;
    end else begin
      rob_valid <= |fu_rob_ack;
      if (|fu_rob_ack) begin
        rob_robid <= rob_robid_mux;
        rob_flags <= rob_flags_mux;
        rob_wbs   <= rob_wbs_mux;
        rob_value <= rob_value_mux;
        rob_ptr   <= rob_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_result_bus_arbiter
//
// Directed scenarios with hand-computed expectations, then a randomized phase.
// A behavioural model, expressed as "requester at the smallest rotational
// distance from the pointer wins", is compared with the DUT on every falling
// edge.
// -----------------------------------------------------------------------------
module tb_result_bus_arbiter;

  localparam int NFU    = 4;
  localparam int ID_W   = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst, flush, rob_ready;

  logic [NFU-1:0]         fu_cdb_req, fu_cdb_ack;
  logic [NFU*ID_W-1:0]    fu_cdb_id;
  logic [NFU*DATA_W-1:0]  fu_cdb_val;
  logic                   cdb_valid;
  logic [ID_W-1:0]        cdb_id;
  logic [DATA_W-1:0]      cdb_val;

  logic [NFU-1:0]         fu_rob_req, fu_rob_ack;
  logic [NFU*ID_W-1:0]    fu_rob_robid;
  logic [NFU*DATA_W-1:0]  fu_rob_flags, fu_rob_wbs, fu_rob_value;
  logic                   rob_valid;
  logic [ID_W-1:0]        rob_robid;
  logic [DATA_W-1:0]      rob_flags, rob_wbs, rob_value;

  // Per-FU stimulus arrays, packed onto the flat ports below.
  logic [ID_W-1:0]   c_id  [NFU];
  logic [DATA_W-1:0] c_val [NFU];
  logic [ID_W-1:0]   r_id  [NFU];
  logic [DATA_W-1:0] r_flg [NFU];
  logic [DATA_W-1:0] r_wbs [NFU];
  logic [DATA_W-1:0] r_val [NFU];

  for (genvar k = 0; k < NFU; k++) begin : g_pack
    assign fu_cdb_id[k*ID_W +: ID_W]       = c_id[k];
    assign fu_cdb_val[k*DATA_W +: DATA_W]  = c_val[k];
    assign fu_rob_robid[k*ID_W +: ID_W]    = r_id[k];
    assign fu_rob_flags[k*DATA_W +: DATA_W] = r_flg[k];
    assign fu_rob_wbs[k*DATA_W +: DATA_W]  = r_wbs[k];
    assign fu_rob_value[k*DATA_W +: DATA_W] = r_val[k];
  end

  result_bus_arbiter #(.NFU(NFU), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fu_cdb_req   (fu_cdb_req),
    .fu_cdb_id    (fu_cdb_id),
    .fu_cdb_val   (fu_cdb_val),
    .fu_cdb_ack   (fu_cdb_ack),
    .cdb_valid    (cdb_valid),
    .cdb_id       (cdb_id),
    .cdb_val      (cdb_val),
    .fu_rob_req   (fu_rob_req),
    .fu_rob_robid (fu_rob_robid),
    .fu_rob_flags (fu_rob_flags),
    .fu_rob_wbs   (fu_rob_wbs),
    .fu_rob_value (fu_rob_value),
    .rob_ready    (rob_ready),
    .fu_rob_ack   (fu_rob_ack),
    .rob_valid    (rob_valid),
    .rob_robid    (rob_robid),
    .rob_flags    (rob_flags),
    .rob_wbs      (rob_wbs),
    .rob_value    (rob_value)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the winner is the requester whose rotational distance
  // (k - ptr) mod NFU is smallest. m_* hold the expected registered outputs.
  // ---------------------------------------------------------------------------
  function automatic int winner(input logic [NFU-1:0] req, input int ptr);
    int best      = -1;
    int best_dist = NFU;
    for (int k = 0; k < NFU; k++) begin
      if (req[k] && ((k - ptr + NFU) % NFU) < best_dist) begin
        best      = k;
        best_dist = (k - ptr + NFU) % NFU;
      end
    end
    return best;
  endfunction

  bit                m_known = 1'b0;
  int                m_cptr, m_rptr;
  logic              m_cvalid, m_rvalid;
  logic [ID_W-1:0]   m_cid, m_rid;
  logic [DATA_W-1:0] m_cval, m_rflg, m_rwbs, m_rval;

  always @(negedge clk) begin
    int cw, rw;
    logic [NFU-1:0] e_cack, e_rack;
    cw = (rst || flush) ? -1 : winner(fu_cdb_req, m_cptr);
    rw = (rst || flush || !rob_ready) ? -1 : winner(fu_rob_req, m_rptr);
    e_cack = '0;
    e_rack = '0;
    if (cw >= 0) e_cack[cw] = 1'b1;
    if (rw >= 0) e_rack[rw] = 1'b1;
    if (m_known) begin
      check("model cdb_ack", 64'(fu_cdb_ack), 64'(e_cack));
      check("model rob_ack", 64'(fu_rob_ack), 64'(e_rack));
      check("model cdb_out", 64'({cdb_valid, cdb_id, cdb_val}),
            64'({m_cvalid, m_cid, m_cval}));
      check("model rob_out", 64'({rob_valid, rob_robid, rob_flags, rob_wbs, rob_value}),
            64'({m_rvalid, m_rid, m_rflg, m_rwbs, m_rval}));
    end
    if (rst) begin
      m_known  = 1'b1;
      m_cptr   = 0;      m_rptr   = 0;
      m_cvalid = 1'b0;   m_rvalid = 1'b0;
      m_cid    = '0;     m_cval   = '0;
      m_rid    = '0;     m_rflg   = '0;   m_rwbs = '0;   m_rval = '0;
    end else if (m_known) begin
      m_cvalid = (cw >= 0);
      if (cw >= 0) begin
        m_cid  = c_id[cw];
        m_cval = c_val[cw];
        m_cptr = (cw + 1) % NFU;
      end
      m_rvalid = (rw >= 0);
      if (rw >= 0) begin
        m_rid  = r_id[rw];
        m_rflg = r_flg[rw];
        m_rwbs = r_wbs[rw];
        m_rval = r_val[rw];
        m_rptr = (rw + 1) % NFU;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    rob_ready  = 1'b1;
    fu_cdb_req = '1;
    fu_rob_req = '0;
    for (int k = 0; k < NFU; k++) begin
      c_id[k]  = ID_W'(k + 1);
      c_val[k] = DATA_W'(8'h10 + k);
      r_id[k]  = ID_W'(k + 9);
      r_flg[k] = DATA_W'(8'h20 + k);
      r_wbs[k] = DATA_W'(8'h30 + k);
      r_val[k] = DATA_W'(8'h40 + k);
    end

    // Reset held two cycles with every CDB request high.
    cyc();
    #1;
    check("reset cdb_ack", 64'(fu_cdb_ack), 64'h0);
    check("reset rob_ack", 64'(fu_rob_ack), 64'h0);
    check("reset cdb_out", 64'({cdb_valid, cdb_id, cdb_val}), 64'h0);
    check("reset rob_out", 64'({rob_valid, rob_robid, rob_flags, rob_wbs, rob_value}), 64'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("first grant FU0", 64'(fu_cdb_ack), 64'b0001);

    // Round robin over all four FUs.
    for (int n = 1; n <= 4; n++) begin
      cyc();
      #1;
      check("rr cdb_valid", 64'(cdb_valid), 64'h1);
      check("rr cdb_id", 64'(cdb_id), 64'(n));
      check("rr cdb_val", 64'(cdb_val), 64'(8'h10 + n - 1));
      check("rr cdb_ack", 64'(fu_cdb_ack), 64'(1 << (n % 4)));
    end

    // Single requester FU2 (pointer currently 1).
    cyc();
    fu_cdb_req = 4'b0100;
    c_id[2]    = 4'd7;
    c_val[2]   = 8'h80;
    #1;
    check("rr wrap cdb_id", 64'(cdb_id), 64'd1);
    check("single ack", 64'(fu_cdb_ack), 64'b0100);
    cyc();
    fu_cdb_req = '0;
    #1;
    check("single cdb_out", 64'({cdb_valid, cdb_id, cdb_val}), 64'({1'b1, 4'd7, 8'h80}));
    check("idle ack", 64'(fu_cdb_ack), 64'h0);

    // ROB backpressure on FU1; CDB keeps going (its pointer is 3 now).
    cyc();
    fu_cdb_req = '1;
    fu_rob_req = 4'b0010;
    r_id[1]    = 4'd5;
    rob_ready  = 1'b0;
    #1;
    check("idle cdb_valid", 64'(cdb_valid), 64'h0);
    check("ptr3 cdb_ack", 64'(fu_cdb_ack), 64'b1000);
    check("stall rob_ack", 64'(fu_rob_ack), 64'h0);
    for (int n = 0; n < 2; n++) begin
      cyc();
      #1;
      check("stall rob_ack", 64'(fu_rob_ack), 64'h0);
      check("stall rob_valid", 64'(rob_valid), 64'h0);
      check("stall cdb_valid", 64'(cdb_valid), 64'h1);
      check("stall cdb_ack", 64'(fu_cdb_ack), 64'(1 << n));
    end
    cyc();
    rob_ready = 1'b1;
    #1;
    check("ready rob_ack", 64'(fu_rob_ack), 64'b0010);
    check("ready rob_valid", 64'(rob_valid), 64'h0);
    cyc();
    fu_rob_req = '0;
    fu_cdb_req = 4'b1000;
    #1;
    check("rob write", 64'({rob_valid, rob_robid}), 64'({1'b1, 4'd5}));
    check("rob fields", 64'({rob_flags, rob_wbs, rob_value}), 64'h213141);
    check("fu3 cdb_ack", 64'(fu_cdb_ack), 64'b1000);

    // Flush with FU0 and FU3 requesting (CDB pointer 0, ROB pointer 2).
    cyc();
    fu_cdb_req = 4'b1001;
    fu_rob_req = 4'b1001;
    flush      = 1'b1;
    #1;
    check("flush cdb_ack", 64'(fu_cdb_ack), 64'h0);
    check("flush rob_ack", 64'(fu_rob_ack), 64'h0);
    check("flush completes", 64'(cdb_valid), 64'h1);
    cyc();
    flush = 1'b0;
    #1;
    check("post-flush valids", 64'({cdb_valid, rob_valid}), 64'b00);
    check("post-flush cdb_ack", 64'(fu_cdb_ack), 64'b0001);
    check("post-flush rob_ack", 64'(fu_rob_ack), 64'b1000);

    // Dual channel: FU3 wins both (CDB pointer 1, ROB pointer 0).
    cyc();
    fu_cdb_req = 4'b1000;
    fu_rob_req = 4'b1000;
    #1;
    check("dual cdb_ack", 64'(fu_cdb_ack), 64'b1000);
    check("dual rob_ack", 64'(fu_rob_ack), 64'b1000);
    cyc();
    fu_cdb_req = '1;
    fu_rob_req = '1;
    #1;
    check("dual valids", 64'({cdb_valid, rob_valid}), 64'b11);
    check("dual ids", 64'({cdb_id, rob_robid}), 64'({4'd4, 4'd12}));
    check("dual ptr0 cdb", 64'(fu_cdb_ack), 64'b0001);
    check("dual ptr0 rob", 64'(fu_rob_ack), 64'b0001);

    // Reset mid-operation drops pending requests and returns pointers to 0.
    cyc();
    rst = 1'b1;
    #1;
    check("mid rst acks", 64'({fu_cdb_ack, fu_rob_ack}), 64'h0);
    cyc();
    rst = 1'b0;
    #1;
    check("mid rst outs", 64'({cdb_valid, cdb_id, rob_valid, rob_robid}), 64'h0);
    check("mid rst ptr", 64'({fu_cdb_ack, fu_rob_ack}), 64'h11);

    // Randomized phase, checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst        = ($urandom_range(0, 99) < 2);
      flush      = ($urandom_range(0, 99) < 8);
      rob_ready  = ($urandom_range(0, 3) != 0);
      fu_cdb_req = NFU'($urandom);
      fu_rob_req = NFU'($urandom);
      for (int k = 0; k < NFU; k++) begin
        c_id[k]  = ID_W'($urandom);
        c_val[k] = DATA_W'($urandom);
        r_id[k]  = ID_W'($urandom);
        r_flg[k] = DATA_W'($urandom);
        r_wbs[k] = DATA_W'($urandom);
        r_val[k] = DATA_W'($urandom);
      end
    end

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
